// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body block: direction and state
// encodings, coordinate widths and the packed {y, x} position record.
package snake_pkg;

   localparam int XY_W   = 5;
   localparam int GRID_N = 32;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_e;

   typedef struct packed {
      logic [XY_W-1:0] y;
      logic [XY_W-1:0] x;
   } pos_t;

   // Opposite directions differ only in bit 0 (up/down, left/right).
   function automatic dir_e dir_reverse(input dir_e d);
      return dir_e'(d ^ 2'b01);
   endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator: moves the head one cell in the given
// direction with 5-bit wrapping arithmetic and flags when the move crossed
// the grid edge.
module snake_next_head
   import snake_pkg::*;
(
   input  pos_t head,
   input  dir_e dir,
   output pos_t next_head,
   output logic out_of_range
);

   // One-cell move plus edge-crossing detection.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      next_head    = head;
      out_of_range = 1'b0;
      case (dir)
         DIR_UP: begin
            next_head.y  = head.y - 5'd1;
            out_of_range = (head.y == 5'd0);
         end
         DIR_DOWN: begin
            next_head.y  = head.y + 5'd1;
            out_of_range = (head.y == 5'(GRID_N - 1));
         end
         DIR_LEFT: begin
            next_head.x  = head.x - 5'd1;
            out_of_range = (head.x == 5'd0);
         end
         DIR_RIGHT: begin
            next_head.x  = head.x + 5'd1;
            out_of_range = (head.x == 5'(GRID_N - 1));
         end
         default: begin
            next_head    = head;
            out_of_range = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/snake_body.sv
// Snake body register: holds the packed segment list, applies steps, turns
// and growth, and tracks IDLE/RUN/DEAD. Define SNAKE_WALL_WRAP_EN to make
// the head wrap around the grid edge instead of dying there.
module snake_body
   import snake_pkg::*;
#(
   parameter int SEG_NUM  = 16,
   parameter int SEG_W    = 16,
   parameter int POS_W    = 10,
   parameter int INIT_LEN = 3,
   parameter int START_X  = 16,
   parameter int START_Y  = 16
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     step,
   input  logic                     dir_valid,
   input  logic [1:0]               dir,
   input  logic                     grow,
   input  logic                     stop,
   output logic [SEG_NUM*SEG_W-1:0] snake,
   output logic [4:0]               length,
   output logic                     alive,
   output logic                     move_done
);

`ifdef SNAKE_WALL_WRAP_EN
   localparam bit WALL_KILLS = 1'b0;
`else
   localparam bit WALL_KILLS = 1'b1;
`endif

   state_e     state_q, state_d;
   pos_t       seg_q [SEG_NUM];
   pos_t       seg_d [SEG_NUM];
   logic [4:0] len_q, len_d;
   dir_e       cur_dir_q, cur_dir_d;
   dir_e       pend_dir_q, pend_dir_d;
   logic       pend_vld_q, pend_vld_d;
   logic       grow_q, grow_d;
   logic       alive_q, alive_d;
   logic       move_done_q, move_done_d;

   dir_e       step_dir;
   pos_t       next_head;
   logic       head_oob;
   logic       grow_eff;
   logic [4:0] new_len;
   int         last_idx;

   // Direction used by a step: the pending turn unless it would reverse.
   always_comb begin
      step_dir = cur_dir_q;
      if (pend_vld_q && (pend_dir_q != dir_reverse(cur_dir_q))) begin
         step_dir = pend_dir_q;
      end
   end

   snake_next_head u_next_head (
      .head         (seg_q[0]),
      .dir          (step_dir),
      .next_head    (next_head),
      .out_of_range (head_oob)
   );

   // Length after a step, and the index of the tail segment it implies.
   always_comb begin
      grow_eff = grow_q | grow;
      new_len  = len_q;
      if (grow_eff && (len_q < 5'(SEG_NUM))) begin
         new_len = len_q + 5'd1;
      end
      last_idx = (new_len == 5'd0) ? 0 : int'(new_len) - 1;
   end

   // Next-state logic for the FSM, body, length and direction flags.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cur_dir_d   = cur_dir_q;
      pend_dir_d  = pend_dir_q;
      pend_vld_d  = pend_vld_q;
      grow_d      = grow_q;
      move_done_d = 1'b0;
      for (int i = 0; i < SEG_NUM; i++) begin
         seg_d[i] = seg_q[i];
      end

      case (state_q)
         ST_IDLE, ST_DEAD: begin
            if (start) begin
               state_d    = ST_RUN;
               len_d      = 5'(INIT_LEN);
               cur_dir_d  = DIR_RIGHT;
               pend_vld_d = 1'b0;
               grow_d     = 1'b0;
               // Body laid out leftward from the head; unused slots repeat the tail.
               for (int i = 0; i < SEG_NUM; i++) begin
                  seg_d[i].y = 5'(START_Y);
                  seg_d[i].x = 5'(START_X - ((i < INIT_LEN) ? i : INIT_LEN - 1));
               end
            end
         end

         ST_RUN: begin
            if (grow) begin
               grow_d = 1'b1;
            end
            if (stop) begin
               state_d = ST_DEAD;
            end else if (step) begin
               pend_vld_d = 1'b0;
               if (WALL_KILLS && head_oob) begin
                  state_d = ST_DEAD;
               end else begin
                  cur_dir_d   = step_dir;
                  len_d       = new_len;
                  grow_d      = 1'b0;
                  move_done_d = 1'b1;
                  // Shift toward the tail; slots past the tail mirror the new tail.
                  for (int i = 0; i < SEG_NUM; i++) begin
                     if (i == 0 || last_idx == 0) begin
                        seg_d[i] = next_head;
                     end else if (i <= last_idx) begin
                        seg_d[i] = seg_q[i-1];
                     end else begin
                        seg_d[i] = seg_q[last_idx-1];
                     end
                  end
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (dir_valid) begin
         pend_dir_d = dir_e'(dir);
         pend_vld_d = 1'b1;
      end

      alive_d = (state_d == ST_RUN);
   end

   // State and body registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         len_q       <= 5'd0;
         cur_dir_q   <= DIR_RIGHT;
         pend_dir_q  <= DIR_UP;
         pend_vld_q  <= 1'b0;
         grow_q      <= 1'b0;
         alive_q     <= 1'b0;
         move_done_q <= 1'b0;
         // NOTE: the body array is a visible output that must read zero in reset, so it is cleared here.
         for (int i = 0; i < SEG_NUM; i++) begin
            seg_q[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every flop samples the pre-edge values.
         state_q     <= state_d;
         len_q       <= len_d;
         cur_dir_q   <= cur_dir_d;
         pend_dir_q  <= pend_dir_d;
         pend_vld_q  <= pend_vld_d;
         grow_q      <= grow_d;
         alive_q     <= alive_d;
         move_done_q <= move_done_d;
         for (int i = 0; i < SEG_NUM; i++) begin
            seg_q[i] <= seg_d[i];
         end
      end
   end

   for (genvar g = 0; g < SEG_NUM; g++) begin : g_pack
      assign snake[g*SEG_W +: SEG_W] = {{(SEG_W-POS_W){1'b0}}, seg_q[g]};
   end

   assign length    = len_q;
   assign alive     = alive_q;
   assign move_done = move_done_q;

endmodule

// File: tb/tb_snake_body.sv
// Self-checking bench for snake_body: directed vector table, hand-written
// growth/wall/reset sequences, then random stimulus against a list-based
// model of the body. Works with or without SNAKE_WALL_WRAP_EN.
`timescale 1ns/1ps
module tb_snake_body;

   localparam int SEG_NUM  = 16;
   localparam int SEG_W    = 16;
   localparam int INIT_LEN = 3;
   localparam int SX       = 16;
   localparam int SY       = 16;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic                     start = 1'b0;
   logic                     step = 1'b0;
   logic                     dir_valid = 1'b0;
   logic [1:0]               dir = 2'd0;
   logic                     grow = 1'b0;
   logic                     stop = 1'b0;
   logic [SEG_NUM*SEG_W-1:0] snake;
   logic [4:0]               length;
   logic                     alive;
   logic                     move_done;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   snake_body u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .step      (step),
      .dir_valid (dir_valid),
      .dir       (dir),
      .grow      (grow),
      .stop      (stop),
      .snake     (snake),
      .length    (length),
      .alive     (alive),
      .move_done (move_done)
   );

   // ---------------- reference model: body as a list of (x,y) cells ----------------
   int m_state;             // 0 idle, 1 running, 2 dead
   int m_len;
   int m_x [SEG_NUM];
   int m_y [SEG_NUM];
   int m_cdx, m_cdy;
   bit m_pv;
   int m_pdx, m_pdy;
   bit m_grow;
   bit m_md;

   function automatic void dir_vec(input logic [1:0] d, output int dx, output int dy);
      dx = 0; dy = 0;
      case (d)
         2'd0: dy = -1;
         2'd1: dy = 1;
         2'd2: dx = -1;
         default: dx = 1;
      endcase
   endfunction

   function automatic void model_reset();
      m_state = 0; m_len = 0; m_pv = 0; m_grow = 0; m_md = 0;
      m_cdx = 1; m_cdy = 0; m_pdx = 0; m_pdy = 0;
      for (int i = 0; i < SEG_NUM; i++) begin m_x[i] = 0; m_y[i] = 0; end
   endfunction

   function automatic void model_apply(input bit st, input bit sp, input bit dv,
                                       input logic [1:0] d, input bit g, input bit so);
      int nx, ny;
      bit hit;
      m_md = 0;
      if (m_state != 1) begin
         if (st) begin
            m_state = 1; m_len = INIT_LEN;
            for (int i = 0; i < SEG_NUM; i++) begin
               m_x[i] = ((SX - i) % 32 + 32) % 32;
               m_y[i] = SY;
            end
            m_cdx = 1; m_cdy = 0; m_pv = 0; m_grow = 0;
         end
      end else begin
         if (g) m_grow = 1;
         if (so) begin
            m_state = 2;
         end else if (sp) begin
            if (m_pv && !(m_pdx == -m_cdx && m_pdy == -m_cdy)) begin
               m_cdx = m_pdx; m_cdy = m_pdy;
            end
            m_pv = 0;
            nx = m_x[0] + m_cdx;
            ny = m_y[0] + m_cdy;
            hit = (nx < 0) || (nx > 31) || (ny < 0) || (ny > 31);
`ifdef SNAKE_WALL_WRAP_EN
            nx = (nx + 32) % 32;
            ny = (ny + 32) % 32;
            hit = 0;
`endif
            if (hit) begin
               m_state = 2;
            end else begin
               if (m_grow && m_len < SEG_NUM) m_len++;
               m_grow = 0;
               for (int i = m_len - 1; i > 0; i--) begin
                  m_x[i] = m_x[i-1]; m_y[i] = m_y[i-1];
               end
               m_x[0] = nx; m_y[0] = ny;
               m_md = 1;
            end
         end
      end
      if (dv) begin
         dir_vec(d, m_pdx, m_pdy);
         m_pv = 1;
      end
   endfunction

   function automatic logic [SEG_NUM*SEG_W-1:0] model_snake();
      logic [SEG_NUM*SEG_W-1:0] r;
      int k;
      r = '0;
      if (m_len > 0) begin
         for (int i = 0; i < SEG_NUM; i++) begin
            k = (i < m_len) ? i : m_len - 1;
            r[i*SEG_W +: SEG_W] = 16'(m_y[k] * 32 + m_x[k]);
         end
      end
      return r;
   endfunction

   // ---------------- helpers ----------------
   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic compare_model(input string tag);
      check({tag, "/snake"}, snake, model_snake());
      check({tag, "/length"}, 256'(length), 256'(m_len));
      check({tag, "/alive"}, 256'(alive), 256'(m_state == 1));
      check({tag, "/move_done"}, 256'(move_done), 256'(m_md));
   endtask

   task automatic do_cycle(input bit st, input bit sp, input bit dv,
                           input logic [1:0] d, input bit g, input bit so);
      start = st; step = sp; dir_valid = dv; dir = d; grow = g; stop = so;
      model_apply(st, sp, dv, d, g, so);
      @(posedge clk);
      #1;
      start = 0; step = 0; dir_valid = 0; dir = 2'd0; grow = 0; stop = 0;
   endtask

   typedef struct {
      bit         st, sp, dv;
      logic [1:0] d;
      bit         g, so;
      int         hx, hy, s1x, s1y, len;
      bit         al, md;
   } vec_t;

   vec_t vecs [17];

   initial begin
      #200_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      logic [1:0] rd;

      //             st sp dv d  g so  hx  hy s1x s1y len al md
      vecs[0]  = '{1, 0, 0, 0, 0, 0, 16, 16, 15, 16, 3, 1, 0}; // start
      vecs[1]  = '{0, 0, 1, 0, 0, 0, 16, 16, 15, 16, 3, 1, 0}; // dir up
      vecs[2]  = '{0, 1, 0, 0, 0, 0, 16, 15, 16, 16, 3, 1, 1}; // step up
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 16, 15, 16, 16, 3, 1, 0}; // pulse ends
      vecs[4]  = '{0, 0, 1, 1, 0, 0, 16, 15, 16, 16, 3, 1, 0}; // dir down (reverse)
      vecs[5]  = '{0, 1, 0, 0, 0, 0, 16, 14, 16, 15, 3, 1, 1}; // keeps going up
      vecs[6]  = '{1, 0, 0, 0, 0, 0, 16, 14, 16, 15, 3, 1, 0}; // start ignored in RUN
      vecs[7]  = '{0, 0, 0, 0, 0, 1, 16, 14, 16, 15, 3, 0, 0}; // stop
      vecs[8]  = '{1, 0, 0, 0, 0, 0, 16, 16, 15, 16, 3, 1, 0}; // restart from DEAD
      vecs[9]  = '{0, 0, 1, 2, 0, 0, 16, 16, 15, 16, 3, 1, 0}; // dir left (reverse)
      vecs[10] = '{0, 1, 0, 0, 0, 0, 17, 16, 16, 16, 3, 1, 1}; // still right
      vecs[11] = '{0, 0, 0, 0, 1, 0, 17, 16, 16, 16, 3, 1, 0}; // grow
      vecs[12] = '{0, 1, 0, 0, 0, 0, 18, 16, 17, 16, 4, 1, 1}; // grows to 4
      vecs[13] = '{0, 1, 0, 0, 0, 0, 19, 16, 18, 16, 4, 1, 1}; // stays 4
      vecs[14] = '{0, 1, 0, 0, 0, 1, 19, 16, 18, 16, 4, 0, 0}; // stop beats step
      vecs[15] = '{0, 1, 0, 0, 0, 0, 19, 16, 18, 16, 4, 0, 0}; // step in DEAD
      vecs[16] = '{0, 0, 0, 0, 1, 0, 19, 16, 18, 16, 4, 0, 0}; // grow in DEAD

      model_reset();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset/snake", snake, '0);
      check("reset/length", 256'(length), 256'(0));
      check("reset/alive", 256'(alive), 256'(0));
      check("reset/move_done", 256'(move_done), 256'(0));

      // Directed vector table.
      for (int i = 0; i < 17; i++) begin
         do_cycle(vecs[i].st, vecs[i].sp, vecs[i].dv, vecs[i].d, vecs[i].g, vecs[i].so);
         check($sformatf("v%0d/hx", i), 256'(snake[4:0]), 256'(vecs[i].hx));
         check($sformatf("v%0d/hy", i), 256'(snake[9:5]), 256'(vecs[i].hy));
         check($sformatf("v%0d/s1x", i), 256'(snake[SEG_W +: 5]), 256'(vecs[i].s1x));
         check($sformatf("v%0d/s1y", i), 256'(snake[SEG_W+5 +: 5]), 256'(vecs[i].s1y));
         check($sformatf("v%0d/len", i), 256'(length), 256'(vecs[i].len));
         check($sformatf("v%0d/alive", i), 256'(alive), 256'(vecs[i].al));
         check($sformatf("v%0d/md", i), 256'(move_done), 256'(vecs[i].md));
         compare_model($sformatf("v%0d", i));
      end

      // Tail replication after start.
      do_cycle(1, 0, 0, 2'd0, 0, 0);
      check("start/seg3", 256'(snake[3*SEG_W +: SEG_W]), 256'(16'(16*32 + 14)));
      check("start/seg15", 256'(snake[15*SEG_W +: SEG_W]), 256'(16'(16*32 + 14)));
      compare_model("start");

      // Grow to capacity, then further growth saturates.
      for (int i = 0; i < 13; i++) begin
         do_cycle(0, 0, 0, 2'd0, 1, 0);
         do_cycle(0, 1, 0, 2'd0, 0, 0);
         compare_model($sformatf("grow%0d", i));
      end
      check("sat/len16", 256'(length), 256'(16));
      do_cycle(0, 0, 0, 2'd0, 1, 0);
      do_cycle(0, 1, 0, 2'd0, 0, 0);
      check("sat/len_hold", 256'(length), 256'(16));
      check("sat/hx30", 256'(snake[4:0]), 256'(30));
      do_cycle(0, 1, 0, 2'd0, 0, 0);
      check("edge/hx31", 256'(snake[4:0]), 256'(31));
      compare_model("edge_pre");

      // Step right off the edge.
      do_cycle(0, 1, 0, 2'd0, 0, 0);
`ifdef SNAKE_WALL_WRAP_EN
      check("wall/hx", 256'(snake[4:0]), 256'(0));
      check("wall/alive", 256'(alive), 256'(1));
      check("wall/md", 256'(move_done), 256'(1));
`else
      check("wall/hx", 256'(snake[4:0]), 256'(31));
      check("wall/alive", 256'(alive), 256'(0));
      check("wall/md", 256'(move_done), 256'(0));
`endif
      check("wall/hy", 256'(snake[9:5]), 256'(16));
      compare_model("wall");

      // Asynchronous reset in the middle of a run.
      do_cycle(1, 0, 0, 2'd0, 0, 0);
      do_cycle(0, 1, 0, 2'd0, 0, 0);
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst/snake", snake, '0);
      check("midrst/length", 256'(length), 256'(0));
      check("midrst/alive", 256'(alive), 256'(0));
      #2 rst_n = 1'b1;
      do_cycle(0, 1, 0, 2'd0, 1, 0);
      compare_model("post_rst");
      check("post_rst/alive", 256'(alive), 256'(0));

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         r  = $urandom_range(0, 99);
         rd = 2'($urandom_range(0, 3));
         if (r < 40)      do_cycle(0, 1, 0, 2'd0, 0, 0);
         else if (r < 65) do_cycle(0, 0, 1, rd, 0, 0);
         else if (r < 75) do_cycle(0, 0, 0, 2'd0, 1, 0);
         else if (r < 80) do_cycle(1, 0, 0, 2'd0, 0, 0);
         else if (r < 82) do_cycle(0, 0, 0, 2'd0, 0, 1);
         else             do_cycle(0, 0, 0, 2'd0, 0, 0);
         compare_model($sformatf("rnd%0d", c));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
